// File: rtl/uncached_write_buffer_if.sv
// Write-port bundle between the uncached write buffer and the shared AXI3 write channel,
// including the request/grant pair used to arbitrate for that port.
interface uncached_write_buffer_if;
  logic        req;
  logic        grnt;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // AW, W and B each complete a transfer on a rising edge where valid and ready are both
  // high; the source raises valid without waiting for ready and holds valid and payload
  // stable until that edge.
  modport master (
    output req,
    input  grnt,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  req,
    output grnt,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/uncached_write_buffer.sv
// Posted-write FIFO for uncached stores, drained in order as single-beat AXI3 writes.
// Define UNCACHED_WB_BRESP_WAIT_EN to retire entries only on a matching B response.
module uncached_write_buffer #(
  parameter int          DEPTH  = 4,
  parameter logic [3:0]  AXI_ID = 4'b0010
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_uncached,
  input  logic                       cpu_we,
  input  logic [31:0]                cpu_addr,
  input  logic [3:0]                 cpu_byte_enable,
  input  logic [31:0]                cpu_wdata,
  output logic                       cpu_stall,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       wr_err,
  output logic [1:0]                 dbg_state,
  uncached_write_buffer_if.master    axi
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
`ifdef UNCACHED_WB_BRESP_WAIT_EN
    S_RESP = 2'd3,
`endif
    S_XFER = 2'd2
  } state_t;

  state_t        state;
  logic [29:0]   mem_addr [DEPTH];
  logic [3:0]    mem_be   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          push;
  logic          pop;
  logic          xfer_done;

  // A pop in the same cycle never frees a slot for a store that arrived while full.
  assign full      = (cnt == CW'(DEPTH));
  assign push      = cpu_uncached & cpu_we & ~full;
  assign cpu_stall = cpu_uncached & cpu_we & full;
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign dbg_state = state;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = {mem_addr[rd_ptr], 2'b00};
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b00;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = mem_data[rd_ptr];
  assign axi.wstrb   = mem_be[rd_ptr];

  // Each channel is done once its valid has dropped or is being accepted this edge.
  assign xfer_done = (state == S_XFER)
                   & (~axi.awvalid | axi.awready)
                   & (~axi.wvalid  | axi.wready);

`ifdef UNCACHED_WB_BRESP_WAIT_EN
  assign pop        = (state == S_RESP) & axi.bvalid & (axi.bid == AXI_ID);
  assign axi.bready = (state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if (pop && (axi.bresp != 2'b00)) begin
      wr_err <= 1'b1;
    end
  end
`else
  logic unused_b;

  assign pop        = xfer_done;
  assign axi.bready = 1'b1;
  assign wr_err     = 1'b0;
  assign unused_b   = ^{axi.bid, axi.bresp, axi.bvalid};
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cpu_addr[31:2];
      mem_be[wr_ptr]   <= cpu_byte_enable;
      mem_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      axi.req     <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.wlast   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cnt != '0) begin
            axi.req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (axi.grnt) begin
            axi.awvalid <= 1'b1;
            axi.wvalid  <= 1'b1;
            axi.wlast   <= 1'b1;
            state       <= S_XFER;
          end
        end
        S_XFER: begin
          if (axi.awvalid && axi.awready) axi.awvalid <= 1'b0;
          if (axi.wvalid && axi.wready) begin
            axi.wvalid <= 1'b0;
            axi.wlast  <= 1'b0;
          end
          if (xfer_done) begin
`ifdef UNCACHED_WB_BRESP_WAIT_EN
            state <= S_RESP;
`else
            axi.req <= 1'b0;
            state   <= S_IDLE;
`endif
          end
        end
`ifdef UNCACHED_WB_BRESP_WAIT_EN
        S_RESP: begin
          if (pop) begin
            axi.req <= 1'b0;
            state   <= S_IDLE;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
